// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, bus field layouts and load-type decode.
package mem_stage_pkg;

  localparam int unsigned EX_MEM_LEN = 76;
  localparam int unsigned MEM_WB_LEN = 70;
  localparam int unsigned MEM_RF_LEN = 38;

  // ld_inst bit positions: {ld_w, ld_b, ld_h, ld_bu, ld_hu}
  localparam int unsigned LD_W_BIT  = 4;
  localparam int unsigned LD_B_BIT  = 3;
  localparam int unsigned LD_H_BIT  = 2;
  localparam int unsigned LD_BU_BIT = 1;
  localparam int unsigned LD_HU_BIT = 0;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [4:0]  ld_inst;
  } ex_mem_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
    logic [31:0] pc;
  } mem_wb_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } mem_rf_bus_t;

  typedef enum logic [2:0] {
    LDK_RAW,
    LDK_W,
    LDK_B,
    LDK_H,
    LDK_BU,
    LDK_HU
  } ld_kind_t;

  // ld_inst is one-hot; an all-zero vector selects raw read data.
  function automatic ld_kind_t decode_ld(input logic [4:0] ld_inst);
    ld_kind_t k;
    k = LDK_RAW;
    if (ld_inst[LD_W_BIT])       k = LDK_W;
    else if (ld_inst[LD_B_BIT])  k = LDK_B;
    else if (ld_inst[LD_H_BIT])  k = LDK_H;
    else if (ld_inst[LD_BU_BIT]) k = LDK_BU;
    else if (ld_inst[LD_HU_BIT]) k = LDK_HU;
    return k;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment and extension: selects byte/halfword lanes from the SRAM word.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  ld_inst,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    // Halfword lane ignores addr_lo[0]; misalignment is not trapped here.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (decode_ld(ld_inst))
      LDK_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LDK_BU:  load_data = {24'h0, byte_sel};
      LDK_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LDK_HU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX->MEM bus, holds SRAM read data across WB stalls,
// extends loads and drives the WB bus plus the ID forwarding bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned EX_MEM_LEN = mem_stage_pkg::EX_MEM_LEN,
  parameter int unsigned MEM_WB_LEN = mem_stage_pkg::MEM_WB_LEN
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  MEM_allowin,
  input  logic                  EX_MEM_valid,
  input  logic [EX_MEM_LEN-1:0] EX_MEM_bus,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  WB_allowin,
  output logic                  MEM_WB_valid,
  output logic [MEM_WB_LEN-1:0] MEM_WB_bus,
  output logic [37:0]           MEM_rf_bus
);

  logic        ready_go;
  logic        mem_valid_q, mem_valid_d;
  ex_mem_bus_t bus_q, bus_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        rbuf_vld_q, rbuf_vld_d;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] final_result;
  mem_wb_bus_t wb_bus;
  mem_rf_bus_t rf_bus;

  assign ready_go     = 1'b1;
  assign MEM_allowin  = ~mem_valid_q | (ready_go & WB_allowin);
  assign MEM_WB_valid = mem_valid_q & ready_go;

  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    rbuf_d      = rbuf_q;
    rbuf_vld_d  = rbuf_vld_q;
    if (MEM_allowin) begin
      mem_valid_d = EX_MEM_valid;
    end
    if (EX_MEM_valid && MEM_allowin) begin
      bus_d = ex_mem_bus_t'(EX_MEM_bus);
    end
    // Capture only in the first stalled cycle: the SRAM output is guaranteed for
    // that cycle alone, and a younger access may overwrite it afterwards.
    if (MEM_allowin) begin
      rbuf_vld_d = 1'b0;
    end else if (mem_valid_q && !rbuf_vld_q) begin
      rbuf_d     = data_sram_rdata;
      rbuf_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      rbuf_q      <= '0;
      rbuf_vld_q  <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      rbuf_q      <= rbuf_d;
      rbuf_vld_q  <= rbuf_vld_d;
    end
  end

  assign rdata_eff = rbuf_vld_q ? rbuf_q : data_sram_rdata;

  mem_load_ext u_load_ext (
    .rdata     (rdata_eff),
    .addr_lo   (bus_q.alu_result[1:0]),
    .ld_inst   (bus_q.ld_inst),
    .load_data (load_data)
  );

  assign final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;

  always_comb begin
    wb_bus.rf_we        = bus_q.rf_we;
    wb_bus.rf_waddr     = bus_q.rf_waddr;
    wb_bus.final_result = final_result;
    wb_bus.pc           = bus_q.pc;
    rf_bus.rf_we        = bus_q.rf_we & mem_valid_q;
    rf_bus.rf_waddr     = bus_q.rf_waddr;
    rf_bus.result       = final_result;
  end

  assign MEM_WB_bus = wb_bus;
  assign MEM_rf_bus = rf_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        MEM_allowin;
  logic        EX_MEM_valid;
  logic [75:0] EX_MEM_bus;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        MEM_WB_valid;
  logic [69:0] MEM_WB_bus;
  logic [37:0] MEM_rf_bus;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the instruction occupying MEM, whether this is its first MEM cycle,
  // and the read data it saw in that first cycle.
  logic        m_valid;
  logic [75:0] m_bus;
  logic        m_first;
  logic [31:0] m_rd;

  mem_stage #(.EX_MEM_LEN(76), .MEM_WB_LEN(70)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .MEM_allowin     (MEM_allowin),
    .EX_MEM_valid    (EX_MEM_valid),
    .EX_MEM_bus      (EX_MEM_bus),
    .data_sram_rdata (data_sram_rdata),
    .WB_allowin      (WB_allowin),
    .MEM_WB_valid    (MEM_WB_valid),
    .MEM_WB_bus      (MEM_WB_bus),
    .MEM_rf_bus      (MEM_rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [75:0] mk(input logic rfm, input logic we, input logic [4:0] wa,
                                     input logic [31:0] alu, input logic [31:0] pc,
                                     input logic [4:0] ld);
    return {rfm, we, wa, alu, pc, ld};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [4:0] ld);
    logic [31:0] sb, sh;
    logic [7:0]  b;
    logic [15:0] h;
    sb = rd >> (8 * a);
    b  = sb[7:0];
    sh = a[1] ? (rd >> 16) : rd;
    h  = sh[15:0];
    case (ld)
      5'b10000: return rd;
      5'b01000: return {{24{b[7]}}, b};
      5'b00100: return {{16{h[15]}}, h};
      5'b00010: return {24'h0, b};
      5'b00001: return {16'h0, h};
      default:  return rd;
    endcase
  endfunction

  task automatic model_check();
    logic [31:0] rd, fin;
    chk("allowin", {69'h0, MEM_allowin}, {69'h0, (!m_valid || WB_allowin)});
    chk("wb_valid", {69'h0, MEM_WB_valid}, {69'h0, m_valid});
    if (m_valid) begin
      rd  = m_first ? data_sram_rdata : m_rd;
      fin = m_bus[75] ? ref_load(rd, m_bus[38:37], m_bus[4:0]) : m_bus[68:37];
      chk("wb_bus", MEM_WB_bus, {m_bus[74], m_bus[73:69], fin, m_bus[36:5]});
      chk("rf_bus", {32'h0, MEM_rf_bus}, {32'h0, m_bus[74], m_bus[73:69], fin});
    end else begin
      chk("rf_we_idle", {69'h0, MEM_rf_bus[37]}, 70'h0);
    end
  endtask

  task automatic model_next();
    logic allow;
    allow = !m_valid || WB_allowin;
    if (!resetn) begin
      m_valid = 1'b0;
      m_bus   = '0;
      m_first = 1'b0;
    end else if (allow) begin
      m_valid = EX_MEM_valid;
      if (EX_MEM_valid) begin
        m_bus   = EX_MEM_bus;
        m_first = 1'b1;
      end
    end else begin
      if (m_first) m_rd = data_sram_rdata;
      m_first = 1'b0;
    end
  endtask

  // Drive one cycle of inputs and check the model at the following negedge.
  task automatic cyc(input logic ev, input logic [75:0] b, input logic [31:0] rd,
                     input logic wa, input logic rn = 1'b1);
    EX_MEM_valid    = ev;
    EX_MEM_bus      = b;
    data_sram_rdata = rd;
    WB_allowin      = wa;
    resetn          = rn;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic load_test(input string nm, input logic [4:0] ld, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [31:0] exp);
    cyc(1'b1, mk(1'b1, 1'b1, 5'd3, alu, 32'h0000_1000, ld), 32'h0, 1'b1);
    adv();
    cyc(1'b0, '0, rd, 1'b1);
    chk(nm, {38'h0, MEM_WB_bus[63:32]}, {38'h0, exp});
    adv();
  endtask

  initial begin
    m_valid = 1'b0; m_bus = '0; m_first = 1'b0; m_rd = '0;
    resetn = 1'b0; EX_MEM_valid = 1'b0; EX_MEM_bus = '0;
    data_sram_rdata = '0; WB_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cyc(1'b0, '0, 32'h0, 1'b1);
    chk("rst_allowin", {69'h0, MEM_allowin}, 70'h1);
    chk("rst_wb_valid", {69'h0, MEM_WB_valid}, 70'h0);
    chk("rst_rf_we", {69'h0, MEM_rf_bus[37]}, 70'h0);
    adv();

    load_test("ld_b", 5'b01000, 32'h0000_1003, 32'h8000_0000, 32'hFFFF_FF80);
    load_test("ld_bu", 5'b00010, 32'h0000_1003, 32'h8000_0000, 32'h0000_0080);
    load_test("ld_h", 5'b00100, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001);
    load_test("ld_hu", 5'b00001, 32'h0000_2000, 32'h8001_1234, 32'h0000_1234);
    load_test("ld_w", 5'b10000, 32'h0000_2000, 32'h8001_1234, 32'h8001_1234);

    // Non-load
    cyc(1'b1, mk(1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000, 5'b0), 32'h0, 1'b1);
    adv();
    cyc(1'b0, '0, 32'hFFFF_FFFF, 1'b1);
    chk("alu_wb", {32'h0, MEM_WB_bus[69:32]}, {32'h0, 1'b1, 5'd5, 32'h1234_5678});
    chk("alu_rf", {32'h0, MEM_rf_bus}, {32'h0, 1'b1, 5'd5, 32'h1234_5678});
    adv();

    // Stall: first-cycle data must persist while SRAM output changes
    cyc(1'b1, mk(1'b1, 1'b1, 5'd7, 32'h0000_4000, 32'h0000_4000, 5'b10000), 32'h0, 1'b1);
    adv();
    cyc(1'b0, '0, 32'hCAFE_F00D, 1'b0);
    chk("stall_c1", {38'h0, MEM_WB_bus[63:32]}, {38'h0, 32'hCAFE_F00D});
    chk("stall_allowin", {69'h0, MEM_allowin}, 70'h0);
    adv();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, mk(1'b0, 1'b1, 5'd9, 32'h9, 32'h0000_5000, 5'b0), 32'hDEAD_BEEF, 1'b0);
      chk("stall_hold", {38'h0, MEM_WB_bus[63:32]}, {38'h0, 32'hCAFE_F00D});
      adv();
    end
    cyc(1'b1, mk(1'b0, 1'b1, 5'd9, 32'h9, 32'h0000_5000, 5'b0), 32'hDEAD_BEEF, 1'b1);
    chk("stall_release", {38'h0, MEM_WB_bus[63:32]}, {38'h0, 32'hCAFE_F00D});
    chk("release_allowin", {69'h0, MEM_allowin}, 70'h1);
    adv();

    // Back-to-back: four instructions, no bubbles
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, mk(1'b0, 1'b1, 5'd1, 32'(i), 32'h200 + 32'(4 * i), 5'b0), 32'h0, 1'b1);
      if (i >= 1) begin
        chk("b2b_valid", {69'h0, MEM_WB_valid}, 70'h1);
        chk("b2b_pc", {38'h0, MEM_WB_bus[31:0]}, {38'h0, 32'h200 + 32'(4 * (i - 1))});
      end
      adv();
    end
    cyc(1'b0, '0, 32'h0, 1'b1);
    adv();

    // Reset during a stall
    cyc(1'b1, mk(1'b1, 1'b1, 5'd2, 32'h0000_6000, 32'h0000_6000, 5'b10000), 32'h0, 1'b1);
    adv();
    cyc(1'b0, '0, 32'h1111_1111, 1'b0);
    adv();
    cyc(1'b0, '0, 32'h2222_2222, 1'b0, 1'b0);
    adv();
    cyc(1'b1, mk(1'b1, 1'b1, 5'd4, 32'h0000_7000, 32'h0000_7000, 5'b01000), 32'h3333_3333, 1'b1);
    chk("rstst_wb_valid", {69'h0, MEM_WB_valid}, 70'h0);
    chk("rstst_allowin", {69'h0, MEM_allowin}, 70'h1);
    chk("rstst_rf_we", {69'h0, MEM_rf_bus[37]}, 70'h0);
    adv();
    cyc(1'b0, '0, 32'h0000_00A5, 1'b1);
    chk("rstst_live", {38'h0, MEM_WB_bus[63:32]}, {38'h0, 32'hFFFF_FFA5});
    adv();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned k;
      logic [4:0] ld;
      k  = $urandom_range(0, 5);
      ld = (k == 5) ? 5'b0 : 5'(1 << k);
      cyc($urandom_range(0, 3) != 0,
          mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, ld),
          $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
